pc_unit: RTL and testbench

Parametrised successor to the basic program counter. It holds the fetch PC and selects the next PC from the following sources:
- sequential increment
- absolute jump
- PC-relative branch
- trap vector
- trap return
It also keeps an exception PC (epc), a circular return-address stack (RAS) and misalignment detection. It sits at the front of the fetch stage and is driven by the control unit.

---
 rtl/pc_unit.sv | 139 +++++++++++++
 tb/tb_pc_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch program counter: selects the next PC from increment, jump, branch, trap,
// trap return or return-address-stack pop, with misaligned-target trapping.
module pc_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] INIT_ADDR  = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0010,
    parameter int unsigned     INSN_BYTES = 4,
    parameter int unsigned     RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            res,
    input  logic            enable,
    input  logic [2:0]      mode,
    input  logic [XLEN-1:0] jmp_addr,
    input  logic [XLEN-1:0] offset,
    input  logic            push_ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] epc,
    output logic            ras_empty,
    output logic            misalign
);

    localparam int unsigned     ALIGN_W = $clog2(INSN_BYTES);
    localparam int unsigned     PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned     CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSN_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'd0,
        MODE_INC    = 3'd1,
        MODE_JUMP   = 3'd2,
        MODE_BRANCH = 3'd3,
        MODE_TRAP   = 3'd4,
        MODE_TRET   = 3'd5,
        MODE_POP    = 3'd6,
        MODE_RSVD   = 3'd7
    } pc_mode_e;

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_epc;
    logic             r_misalign;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];

    pc_mode_e         w_mode;
    logic [XLEN-1:0]  w_pcInc;
    logic [XLEN-1:0]  w_target;
    logic             w_targetMis;
    logic [PTR_W-1:0] w_popPtr;
    logic             w_rasEmpty;
    logic [XLEN-1:0]  w_nextPc;
    logic [XLEN-1:0]  w_nextEpc;
    logic             w_fault;
    logic             w_push;
    logic             w_pop;

    assign w_mode      = pc_mode_e'(mode);
    assign w_pcInc     = r_pc + STEP;
    assign w_target    = (w_mode == MODE_JUMP) ? jmp_addr : r_pc + offset;
    assign w_targetMis = |w_target[ALIGN_W-1:0];
    assign w_popPtr    = r_ptr - PTR_W'(1);
    assign w_rasEmpty  = (r_cnt == '0);

    // A misaligned jump/branch target is redirected to the trap vector instead.
    always_comb begin
        w_nextPc  = r_pc;
        w_nextEpc = r_epc;
        w_fault   = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        case (w_mode)
            MODE_INC: w_nextPc = w_pcInc;
            MODE_JUMP, MODE_BRANCH: begin
                if (w_targetMis) begin
                    w_fault   = 1'b1;
                    w_nextEpc = r_pc;
                    w_nextPc  = TRAP_VEC;
                end else begin
                    w_nextPc = w_target;
                    w_push   = push_ret;
                end
            end
            MODE_TRAP: begin
                w_nextEpc = r_pc;
                w_nextPc  = TRAP_VEC;
            end
            MODE_TRET: w_nextPc = r_epc;
            MODE_POP: begin
                if (!w_rasEmpty) begin
                    w_nextPc = r_ras[w_popPtr];
                    w_pop    = 1'b1;
                end else begin
                    w_nextPc = w_pcInc;
                end
            end
            default: w_nextPc = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_pc       <= INIT_ADDR;
            r_epc      <= INIT_ADDR;
            r_misalign <= 1'b0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else if (enable) begin
            r_pc       <= w_nextPc;
            r_epc      <= w_nextEpc;
            r_misalign <= w_fault;
            if (w_push) begin
                r_ptr <= r_ptr + PTR_W'(1);
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_ptr <= w_popPtr;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Stack contents need no reset; validity is tracked by r_cnt alone.
    always_ff @(posedge clk) begin
        if (!res && enable && w_push) begin
            r_ras[r_ptr] <= w_pcInc;
        end
    end

    assign pc        = r_pc;
    assign epc       = r_epc;
    assign misalign  = r_misalign;
    assign ras_empty = w_rasEmpty;
    assign pc_next   = res ? INIT_ADDR : w_nextPc;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_pc_unit;

    localparam logic [31:0] INIT = 32'h0000_0000;
    localparam logic [31:0] TVEC = 32'h0000_0010;

    logic        clk;
    logic        res;
    logic        enable;
    logic [2:0]  mode;
    logic [31:0] jmp_addr;
    logic [31:0] offset;
    logic        push_ret;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] epc;
    logic        ras_empty;
    logic        misalign;

    pc_unit dut (
        .clk(clk), .res(res), .enable(enable), .mode(mode),
        .jmp_addr(jmp_addr), .offset(offset), .push_ret(push_ret),
        .pc(pc), .pc_next(pc_next), .epc(epc),
        .ras_empty(ras_empty), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    // Model state: most recent return address lives at the back of the queue.
    logic [31:0] mPc, mEpc;
    logic        mMis;
    logic        mKnown = 1'b0;
    logic [31:0] mRas[$];

    logic [31:0] ePc, eEpc, eRet;
    logic        eMis, ePush, ePop;
    logic [31:0] sampledNext;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic computeExpect();
        logic [31:0] tgt;
        ePc   = mPc;
        eEpc  = mEpc;
        eMis  = 1'b0;
        ePush = 1'b0;
        ePop  = 1'b0;
        eRet  = mPc + 32'd4;
        case (mode)
            3'd1: ePc = mPc + 32'd4;
            3'd2, 3'd3: begin
                tgt = (mode == 3'd2) ? jmp_addr : mPc + offset;
                if (tgt % 4 != 0) begin
                    eEpc = mPc;
                    ePc  = TVEC;
                    eMis = 1'b1;
                end else begin
                    ePc   = tgt;
                    ePush = push_ret;
                end
            end
            3'd4: begin
                eEpc = mPc;
                ePc  = TVEC;
            end
            3'd5: ePc = mEpc;
            3'd6: begin
                if (mRas.size() > 0) begin
                    ePc  = mRas[$];
                    ePop = 1'b1;
                end else begin
                    ePc = mPc + 32'd4;
                end
            end
            default: ePc = mPc;
        endcase
    endtask

    task automatic checkOutput();
        sampledNext = pc_next;
        compare("pc_next", pc_next, res ? INIT : ePc);
        if (mKnown) begin
            compare("pc", pc, mPc);
            compare("epc", epc, mEpc);
            compare("misalign", {31'd0, misalign}, {31'd0, mMis});
            compare("ras_empty", {31'd0, ras_empty}, {31'd0, (mRas.size() == 0)});
        end
    endtask

    task automatic commitModel();
        if (res) begin
            mPc    = INIT;
            mEpc   = INIT;
            mMis   = 1'b0;
            mRas   = {};
            mKnown = 1'b1;
        end else if (enable) begin
            mPc  = ePc;
            mEpc = eEpc;
            mMis = eMis;
            if (ePush) begin
                mRas.push_back(eRet);
                if (mRas.size() > 4) void'(mRas.pop_front());
            end
            if (ePop) void'(mRas.pop_back());
        end
    endtask

    // Drives one cycle of inputs, checks against the model, then crosses the edge.
    task automatic applyStimulus(input logic r, input logic en, input logic [2:0] md,
                                 input logic [31:0] ja, input logic [31:0] off, input logic pr);
        res      = r;
        enable   = en;
        mode     = md;
        jmp_addr = ja;
        offset   = off;
        push_ret = pr;
        #1;
        computeExpect();
        checkOutput();
        @(posedge clk);
        commitModel();
        @(negedge clk);
    endtask

    initial begin
        // Scenario 1: reset then three increments.
        applyStimulus(1, 1, 3'd0, 0, 0, 0);
        compare("t1_pc_reset", pc, 32'h0);
        compare("t1_empty", {31'd0, ras_empty}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 1, 3'd1, 0, 0, 0);
            compare("t1_pc_inc", pc, 32'(4 * i));
        end
        compare("t1_mis", {31'd0, misalign}, 32'd0);

        // Scenario 2: backward branch then misaligned jump.
        applyStimulus(0, 1, 3'd2, 32'h100, 0, 0);
        applyStimulus(0, 1, 3'd3, 0, 32'hFFFF_FFF8, 0);
        compare("t2_branch", pc, 32'hF8);
        applyStimulus(0, 1, 3'd2, 32'h102, 0, 1);
        compare("t2_trap_pc", pc, 32'h10);
        compare("t2_epc", epc, 32'hF8);
        compare("t2_mis_set", {31'd0, misalign}, 32'd1);
        compare("t2_no_push", {31'd0, ras_empty}, 32'd1);
        applyStimulus(0, 1, 3'd1, 0, 0, 0);
        compare("t2_mis_clr", {31'd0, misalign}, 32'd0);

        // Scenario 3: call and return, then pop of an empty stack.
        applyStimulus(0, 1, 3'd2, 32'h200, 0, 0);
        applyStimulus(0, 1, 3'd2, 32'h300, 0, 1);
        applyStimulus(0, 1, 3'd6, 0, 0, 0);
        compare("t3_pop", pc, 32'h204);
        applyStimulus(0, 1, 3'd6, 0, 0, 0);
        compare("t3_pop_empty", pc, 32'h208);
        compare("t3_empty", {31'd0, ras_empty}, 32'd1);

        // Scenario 4: five pushes overflow a four-deep stack.
        applyStimulus(1, 1, 3'd0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 3'd2, 32'(16 * i), 0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 3'd6, 0, 0, 0);
            compare("t4_pop", pc, 32'h44 - 32'(16 * i));
        end
        compare("t4_empty", {31'd0, ras_empty}, 32'd1);

        // Scenario 5: trap, handler step, trap return.
        applyStimulus(0, 1, 3'd2, 32'h500, 0, 0);
        applyStimulus(0, 1, 3'd4, 0, 0, 0);
        compare("t5_trap", pc, 32'h10);
        compare("t5_epc", epc, 32'h500);
        applyStimulus(0, 1, 3'd1, 0, 0, 0);
        compare("t5_inc", pc, 32'h14);
        applyStimulus(0, 1, 3'd5, 0, 0, 0);
        compare("t5_tret", pc, 32'h500);

        // Scenario 6: stall, reset mid-sequence, wrap-around.
        applyStimulus(0, 0, 3'd2, 32'h800, 0, 0);
        compare("t6_stall_next", sampledNext, 32'h800);
        compare("t6_stall_pc", pc, 32'h500);
        applyStimulus(0, 1, 3'd2, 32'h600, 0, 1);
        applyStimulus(1, 1, 3'd6, 0, 0, 0);
        compare("t6_rst_pc", pc, INIT);
        compare("t6_rst_epc", epc, INIT);
        compare("t6_rst_empty", {31'd0, ras_empty}, 32'd1);
        applyStimulus(0, 1, 3'd2, 32'hFFFF_FFFC, 0, 0);
        applyStimulus(0, 1, 3'd1, 0, 0, 0);
        compare("t6_wrap", pc, 32'h0);

        // Randomized traffic, biased toward aligned targets and calls.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ja, off;
            logic [2:0]  md;
            int          so;
            ja = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) ja = ja | 32'($urandom_range(1, 3));
            so = int'($urandom_range(0, 4095)) - 2048;
            off = 32'(so);
            if ($urandom_range(0, 4) != 0) off = off & 32'hFFFF_FFFC;
            md = 3'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, md,
                          ja, off, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
